// File: rtl/booth_mult4_seq.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult4_seq (with four_bit_adder_subtractor)
// Brief    : Sequential radix-2 Booth multiplier, 4x4 signed -> 8-bit product,
//            valid/ready on both sides. Optional macro: BOOTH_ZERO_SKIP_EN.
// Revision : 1.0  initial release
// ============================================================================

module four_bit_adder_subtractor (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       subtract,
    output logic [3:0] Result,
    output logic       Cout
);
    logic [4:0] w_sum;

    assign w_sum  = {1'b0, A} + {1'b0, B ^ {4{subtract}}} + {4'b0000, subtract};
    assign Result = w_sum[3:0];
    assign Cout   = w_sum[4];
endmodule

module booth_mult4_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH != 4) begin : g_width_check
            $error("booth_mult4_seq: WIDTH must be 4 (adder instance is 4-bit)");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_a, r_q, r_m;
    logic               r_qm1;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic               w_add, w_sub, w_cout, w_sign, w_skip;
    logic [WIDTH-1:0]   w_res, w_s, w_a_next, w_q_next;

`ifdef BOOTH_ZERO_SKIP_EN
    assign w_skip = (multiplicand == '0) || (multiplier == '0);
`else
    assign w_skip = 1'b0;
`endif

    // Booth recoding of {Q[0], q_m1}: 01 -> +M, 10 -> -M, else no add.
    assign w_add = r_q[0] ^ r_qm1;
    assign w_sub = r_q[0] & ~r_qm1;

    four_bit_adder_subtractor u_addsub (
        .A        (r_a),
        .B        (r_m),
        .subtract (w_sub),
        .Result   (w_res),
        .Cout     (w_cout)
    );

    // The 5th sum bit is shifted in so that overflowing partial sums stay exact.
    assign w_s      = w_add ? w_res : r_a;
    assign w_sign   = w_add ? (r_a[WIDTH-1] ^ (r_m[WIDTH-1] ^ w_sub) ^ w_cout) : r_a[WIDTH-1];
    assign w_a_next = {w_sign, w_s[WIDTH-1:1]};
    assign w_q_next = {w_s[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_next = w_skip ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == C_CNT_LAST) w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= '0;
                        r_q   <= multiplier;
                        r_qm1 <= 1'b0;
                        r_m   <= multiplicand;
                        r_cnt <= '0;
                        if (w_skip) r_product <= '0;
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_next;
                    r_q   <= w_q_next;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_LAST) r_product <= {w_a_next, w_q_next};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_CALC);
    assign out_valid = (r_state == S_DONE);
    assign product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult4_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mult4_seq
// Brief    : Self-checking bench for booth_mult4_seq against a plain signed
//            multiply model. Honours BOOTH_ZERO_SKIP_EN like the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_booth_mult4_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] multiplicand = '0;
    logic [3:0] multiplier = '0;
    logic       in_ready, out_valid, busy;
    logic [7:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    booth_mult4_seq #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int to_int4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic logic [7:0] ref_mul(input logic [3:0] m, input logic [3:0] q);
        int p;
        p = to_int4(m) * to_int4(q);
        return p[7:0];
    endfunction

    // Latency counts the accept edge as clock 1: out_valid is seen after clock 5.
    function automatic int ref_lat(input logic [3:0] m, input logic [3:0] q);
`ifdef BOOTH_ZERO_SKIP_EN
        if (m == 4'd0 || q == 4'd0) return 1;
`endif
        return 5;
    endfunction

    function automatic int ref_busy(input logic [3:0] m, input logic [3:0] q);
`ifdef BOOTH_ZERO_SKIP_EN
        if (m == 4'd0 || q == 4'd0) return 0;
`endif
        return 4;
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic accept(input logic [3:0] m, input logic [3:0] q);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        multiplicand = m;
        multiplier   = q;
        in_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int nbusy);
        lat = 1;
        nbusy = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) nbusy++;
            if (out_valid) break;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check_eq("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [3:0] m, input logic [3:0] q);
        int lat, nb;
        accept(m, q);
        wait_out(lat, nb);
        check_eq({tag, "_lat"}, lat, ref_lat(m, q));
        check_eq({tag, "_busy"}, nb, ref_busy(m, q));
        check_eq({tag, "_prod"}, {24'd0, product}, {24'd0, ref_mul(m, q)});
        @(negedge clk);
    endtask

    logic [3:0] ext_m [5] = '{4'h8, 4'h7, 4'h8, 4'hF, 4'h8};
    logic [3:0] ext_q [5] = '{4'h8, 4'h8, 4'h7, 4'hF, 4'h1};
    logic [7:0] ext_p [5] = '{8'h40, 8'hC8, 8'hC8, 8'h01, 8'hF8};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb, dly;
        logic [3:0] rm, rq;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_product", {24'd0, product}, 32'd0);

        run_op("basic_3x5", 4'd3, 4'd5);
        check_eq("basic_prod_const", {24'd0, product}, 32'h0F);
        check_eq("basic_in_ready_after", {31'd0, in_ready}, 32'd1);
        check_eq("basic_out_valid_after", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_op("extreme", ext_m[i], ext_q[i]);
            check_eq("extreme_const", {24'd0, product}, {24'd0, ext_p[i]});
        end

        // Backpressure: result must hold and new requests are ignored.
        out_ready = 1'b0;
        accept(4'hD, 4'h6);
        wait_out(lat, nb);
        check_eq("bp_lat", lat, 5);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            multiplicand = 4'h1;
            multiplier = 4'h1;
            check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_product", {24'd0, product}, 32'hEE);
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("bp_product_retained", {24'd0, product}, 32'hEE);

        // Reset on the second CALC cycle.
        accept(4'd5, 4'd5);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_product", {24'd0, product}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        run_op("after_rst_2x2", 4'd2, 4'd2);
        check_eq("after_rst_const", {24'd0, product}, 32'h04);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op("sweep", 4'(i), 4'(j));
            end
        end

        run_op("zero_0xm5", 4'h0, 4'hB);
        check_eq("zero_const", {24'd0, product}, 32'h00);

        // Random pairs with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            rm = 4'($urandom_range(0, 15));
            rq = 4'($urandom_range(0, 15));
            dly = $urandom_range(0, 3);
            out_ready = (dly == 0);
            accept(rm, rq);
            wait_out(lat, nb);
            check_eq("rand_lat", lat, ref_lat(rm, rq));
            check_eq("rand_prod", {24'd0, product}, {24'd0, ref_mul(rm, rq)});
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                check_eq("rand_hold_valid", {31'd0, out_valid}, 32'd1);
                check_eq("rand_hold_prod", {24'd0, product}, {24'd0, ref_mul(rm, rq)});
            end
            out_ready = 1'b1;
            @(negedge clk);
            check_eq("rand_done_cleared", {31'd0, out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/booth_mult4_seq.md
Name: booth_mult4_seq

Overview:
- Sequential radix-2 Booth multiplier for 4-bit two's-complement operands, producing an 8-bit signed product.
- Consumes the existing four_bit_adder_subtractor: one internal instance performs every add/subtract step. Ports are A, B, subtract, Result and Cout.
- Sits directly downstream of operand sources and upstream of any result consumer. Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 4, operand width. Only 4 is legal because the adder instance is 4-bit. Elaboration must fail on any other value.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands; high only in IDLE
- multiplicand  input  4  M, signed
- multiplier  input  4  Q, signed
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  8  signed M*Q
- busy  output  1  high in CALC

Behaviour:
- Reset (rst_n low at a clk edge):
  - state becomes IDLE; product, out_valid, busy and all internal registers become 0.
  - in_ready reads 1 from the first clock after reset.
  - Reset during CALC or DONE aborts the operation and discards the result.
- State IDLE:
  - in_ready = 1.
  - If in_valid=1 at a clk edge, the block captures the operands: acc A=0, Q=multiplier, q_m1=0, M=multiplicand, cnt=0. Next state is CALC.
- State CALC (exactly WIDTH=4 cycles, busy=1):
  - Each cycle examines {Q[0], q_m1}:
    - 01: adder computes A+M (subtract=0).
    - 10: adder computes A-M (subtract=1).
    - 00 or 11: no add; adder result is ignored.
  - Sum S is the adder Result when adding or subtracting, otherwise A.
  - The block then arithmetic-shifts right {A, Q, q_m1} using S in place of A. The bit shifted into A[3] is the true 5-bit sign:
    - when adding or subtracting: A[3] ^ (M[3] ^ subtract) ^ Cout;
    - otherwise: A[3].
  - This makes M = -8 and overflowing intermediate sums exact.
  - cnt increments each cycle. After the 4th shift, the block registers product = {A, Q}, sets out_valid=1 and moves to DONE.
- State DONE:
  - out_valid=1 and product is held stable.
  - When out_ready=1 at a clk edge, out_valid clears next cycle and the state returns to IDLE.
  - out_ready while out_valid=0 has no effect.
- Handshake rules:
  - in_valid outside IDLE is ignored; operands are not queued.
  - Acceptance of a new pair happens at the earliest one cycle after the DONE handshake. There is no overlap.
  - product retains its last value in IDLE until the next DONE.
- Latency: accept edge to out_valid high is 5 clocks, independent of operand values. Throughput is one product per 6 cycles with out_ready tied high.
- Range: all 256 operand pairs are exact. The extremes are -8*-8 = +64 (0x40) and -8*7 = -56 (0xC8).

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined: if multiplicand==0 or multiplier==0 at the accept edge, the block bypasses CALC. It enters DONE next cycle with product=0x00, giving latency 1 clock. busy is never asserted for that operation.
- Undefined: all operations take the full 4 CALC cycles. Zero operands yield 0x00 after 5 clocks.

Test Plan:
- Basic product, out_ready=1: M=3, Q=5 accepted. Requires busy high for 4 cycles, then out_valid high exactly 5 clocks after accept with product=0x0F, then in_ready high again one cycle later.
- Signed extremes, one at a time: (-8)*(-8) -> 0x40; 7*(-8) -> 0xC8; (-8)*7 -> 0xC8; (-1)*(-1) -> 0x01; (-8)*1 -> 0xF8.
- Backpressure: M=-3, Q=6 with out_ready=0 for 10 cycles. Requires out_valid=1 and product=0xEE held stable throughout, in_ready=0, and a new in_valid ignored. Raising out_ready completes the transfer, then IDLE.
- Reset mid-operation: accept M=5, Q=5; drive rst_n=0 for one edge on the 2nd CALC cycle. Next cycle requires state IDLE, out_valid=0, product=0x00, busy=0. A following 2*2 yields 0x04.
- Exhaustive sweep: all 16x16 signed pairs, back-to-back with out_ready=1. Every product must equal the sign-extended reference multiply.
- Zero operand: M=0, Q=-5 -> product 0x00. Latency is 1 clock with BOOTH_ZERO_SKIP_EN defined, 5 clocks without.
